// File: rtl/shift_add_multiplier.sv
// Sequential 9x9 unsigned shift-and-add multiplier. The 9-bit adder lives
// beside this block; it is driven through o_add_* and its result returns on i_add_*.
module shift_add_multiplier #(
    parameter int WIDTH = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product,
    output logic [WIDTH-1:0]     o_add_a,
    output logic [WIDTH-1:0]     o_add_b,
    output logic                 o_add_cin,
    input  logic [WIDTH-1:0]     i_add_s,
    input  logic                 i_add_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [3:0]           r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    // Adder result (carry included) joined with the multiplier, shifted right by one.
    logic [2*WIDTH-1:0]   w_shift;
    assign w_shift = {i_add_cout, i_add_s, r_q[WIDTH-1:1]};

    // Adder drive: only RUN presents operands, every other state holds the adder at zero.
    always_comb begin
        o_add_a   = {WIDTH{1'b0}};
        o_add_b   = {WIDTH{1'b0}};
        o_add_cin = 1'b0;
        if (r_state == S_RUN) begin
            o_add_a = r_acc;
            o_add_b = r_q[0] ? r_mcand : {WIDTH{1'b0}};
        end else begin
            o_add_a = {WIDTH{1'b0}};
            o_add_b = {WIDTH{1'b0}};
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= {WIDTH{1'b0}};
            r_acc     <= {WIDTH{1'b0}};
            r_q       <= {WIDTH{1'b0}};
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_mcand <= i_a;
                        r_q     <= i_b;
                        r_acc   <= {WIDTH{1'b0}};
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_shift[2*WIDTH-1:WIDTH];
                    r_q   <= w_shift[WIDTH-1:0];
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAST_ITER) begin
                        r_product <= w_shift;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier with a behavioural 9-bit adder
// closing the add_* loop and a scoreboard of expected products.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  a_in;
    logic [8:0]  b_in;
    logic        busy;
    logic        done;
    logic [17:0] product;
    logic [8:0]  add_a;
    logic [8:0]  add_b;
    logic        add_cin;
    logic [8:0]  add_s;
    logic        add_cout;

    int checks   = 0;
    int failures = 0;
    int n;
    logic cout_seen;
    logic [17:0] sb[$];

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {9'd0, add_cin};

    shift_add_multiplier #(.WIDTH(9)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_a        (a_in),
        .i_b        (b_in),
        .o_busy     (busy),
        .o_done     (done),
        .o_product  (product),
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .o_add_cin  (add_cin),
        .i_add_s    (add_s),
        .i_add_cout (add_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {14'd0, product}, 32'hFFFF_FFFF);
            end else begin
                check("product", {14'd0, product}, {14'd0, sb.pop_front()});
            end
        end
        if (busy === 1'b1 && add_cout === 1'b1) cout_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] a, input logic [8:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        sb.push_back(18'(a) * 18'(b));
        tick();
        start = 1'b0;
        a_in  = 9'($urandom);
        b_in  = 9'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_drive"}, {14'd0, add_a, add_b, add_cin}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = 9'd0; b_in = 9'd0; cout_seen = 1'b0;
        tick(); tick();
        check_idle("reset");
        check("reset_product", {14'd0, product}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic 5x3: latency, busy width, single-cycle done.
        do_start(9'd5, 9'd3);
        check("basic_busy_rise", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("basic_latency", n, 32'd9);
        check("basic_busy_in_done", {31'd0, busy}, 32'd1);
        tick();
        check_idle("basic_after");
        check("basic_hold", {14'd0, product}, 32'd15);

        // Maximum operands, carry-out must be taken into the accumulator.
        cout_seen = 1'b0;
        do_start(9'h1FF, 9'h1FF);
        wait_done(n);
        check("max_latency", n, 32'd9);
        check("max_cout_seen", {31'd0, cout_seen}, 32'd1);
        tick();

        // Zero multiplicand.
        do_start(9'd0, 9'h1A5);
        wait_done(n);
        check("zero_latency", n, 32'd9);
        tick();

        // Pass-through: multiplier of 1 adds only on the first iteration.
        do_start(9'h1A5, 9'd1);
        check("pass_add_b_first", {23'd0, add_b}, 32'h1A5);
        check("pass_add_a_first", {23'd0, add_a}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("pass_add_b_later", {23'd0, add_b}, 32'd0);
        end
        wait_done(n);
        check("pass_done_seen", {31'd0, done}, 32'd1);
        tick();

        // Start while busy: pulses at E4 and in the DONE cycle are ignored.
        do_start(9'd7, 9'd9);
        tick(); tick(); tick();
        start = 1'b1; a_in = 9'd2; b_in = 9'd2;
        tick();
        start = 1'b0;
        wait_done(n);
        check("busy_start_latency", n, 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_idle", {31'd0, busy}, 32'd0);
        tick(); tick();
        check_idle("busy_start_after");
        check("busy_start_hold", {14'd0, product}, 32'd63);

        // Reset mid-run aborts the multiply.
        do_start(9'd100, 9'd100);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        void'(sb.pop_back());
        tick();
        rst = 1'b0;
        check_idle("abort");
        check("abort_product", {14'd0, product}, 32'd0);
        do_start(9'd3, 9'd4);
        wait_done(n);
        check("after_abort_latency", n, 32'd9);
        tick();

        // Back-to-back with start held high: done every 11 cycles.
        start = 1'b1; a_in = 9'd10; b_in = 9'd20;
        sb.push_back(18'd200);
        tick();
        wait_done(n);
        check("b2b_first_latency", n, 32'd9);
        for (int k = 0; k < 2; k++) begin
            sb.push_back(18'd200);
            tick();
            wait_done(n);
            check("b2b_interval", n + 1, 32'd11);
        end
        start = 1'b0;
        tick(); tick();
        check_idle("b2b_after");

        // A few random operands.
        for (int k = 0; k < 4; k++) begin
            do_start(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
            wait_done(n);
            check("rand_latency", n, 32'd9);
            tick();
        end

        tick();
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
